// File: rtl/regfile_write_sequencer_if.sv
// Writeback handshake and register-file write port of the write sequencer.
// The sequencer takes the slave view; the WB stage and register file take the master view.
interface regfile_write_sequencer_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] rf_writeregister;
  logic [DATA_W-1:0] rf_data;
  logic              rf_regWrite;

  modport master (
    output wb_valid, wb_reg, wb_data,
    input  wb_ready, rf_writeregister, rf_data, rf_regWrite
  );

  modport slave (
    input  wb_valid, wb_reg, wb_data,
    output wb_ready, rf_writeregister, rf_data, rf_regWrite
  );
endinterface

// File: rtl/regfile_write_sequencer.sv
// Queues writeback results and replays them to the register file as setup/strobe/hold,
// with a forwarding lookup over everything still queued.
module regfile_write_sequencer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  regfile_write_sequencer_if.slave     bus,
  input  logic [ADDR_W-1:0]            register1,
  input  logic [ADDR_W-1:0]            register2,
  output logic                         hit1,
  output logic                         hit2,
  output logic [DATA_W-1:0]            fwd_data1,
  output logic [DATA_W-1:0]            fwd_data2,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  head_reg;
  logic [PTR_W-1:0]  tail_reg;
  logic [PTR_W-1:0]  head_next;
  logic [CNT_W-1:0]  count_reg;
  state_t            state_reg;
  logic [ADDR_W-1:0] rf_addr_reg;
  logic [DATA_W-1:0] rf_data_reg;
  logic              rf_we_reg;
  logic              push;
  logic              pop;

  assign bus.wb_ready        = !reset && (count_reg < CNT_W'(DEPTH));
  // Writes to r0 complete the handshake but never occupy a slot.
  assign push                = bus.wb_valid && bus.wb_ready && (bus.wb_reg != '0);
  assign pop                 = (state_reg == HOLD);
  assign head_next           = head_reg + PTR_W'(1);
  assign count               = count_reg;
  assign bus.rf_writeregister = rf_addr_reg;
  assign bus.rf_data         = rf_data_reg;
  assign bus.rf_regWrite     = rf_we_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail_reg] <= bus.wb_reg;
      data_mem[tail_reg] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_reg    <= '0;
      tail_reg    <= '0;
      count_reg   <= '0;
      state_reg   <= IDLE;
      rf_addr_reg <= '0;
      rf_data_reg <= '0;
      rf_we_reg   <= 1'b0;
    end else begin
      if (push) begin
        tail_reg <= tail_reg + PTR_W'(1);
      end
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
      case (state_reg)
        IDLE: begin
          rf_we_reg <= 1'b0;
          if (count_reg != '0) begin
            rf_addr_reg <= addr_mem[head_reg];
            rf_data_reg <= data_mem[head_reg];
            state_reg   <= SETUP;
          end
        end
        SETUP: begin
          rf_we_reg <= 1'b1;
          state_reg <= STROBE;
        end
        STROBE: begin
          rf_we_reg <= 1'b0;
          state_reg <= HOLD;
        end
        HOLD: begin
          // The head stays visible to forwarding until this edge, after the file holds it.
          head_reg <= head_next;
          if (count_reg > CNT_W'(1)) begin
            rf_addr_reg <= addr_mem[head_next];
            rf_data_reg <= data_mem[head_next];
            state_reg   <= SETUP;
          end else begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  logic [PTR_W-1:0] ord_idx [DEPTH];
  logic [DEPTH-1:0] match1;
  logic [DEPTH-1:0] match2;

  // Slot order by age: index 0 is the head (oldest), higher indices are younger.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_lookup
      assign ord_idx[gi] = head_reg + PTR_W'(gi);
      assign match1[gi]  = (CNT_W'(gi) < count_reg) && (register1 != '0) &&
                           (addr_mem[ord_idx[gi]] == register1);
      assign match2[gi]  = (CNT_W'(gi) < count_reg) && (register2 != '0) &&
                           (addr_mem[ord_idx[gi]] == register2);
    end
  endgenerate

  always_comb begin
    hit1      = 1'b0;
    hit2      = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    // Later (younger) matches overwrite earlier ones.
    for (int k = 0; k < DEPTH; k++) begin
      if (match1[k]) begin
        hit1      = 1'b1;
        fwd_data1 = data_mem[ord_idx[k]];
      end
      if (match2[k]) begin
        hit2      = 1'b1;
        fwd_data2 = data_mem[ord_idx[k]];
      end
    end
  end
endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Randomized and directed bench for regfile_write_sequencer against a queue-based model.
module tb_regfile_write_sequencer;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] register1 = '0;
  logic [ADDR_W-1:0] register2 = '0;
  logic              hit1, hit2;
  logic [DATA_W-1:0] fwd_data1, fwd_data2;
  logic [2:0]        count;

  always #5 clk = ~clk;

  regfile_write_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  regfile_write_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .register1 (register1),
    .register2 (register2),
    .hit1      (hit1),
    .hit2      (hit2),
    .fwd_data1 (fwd_data1),
    .fwd_data2 (fwd_data2),
    .count     (count)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t        q[$];
  int          checks = 0;
  int          failures = 0;
  int          edge_n = 0;
  int          pop_timer = 0;
  int          pushed = 0;
  int          strobes = 0;
  int          last_acc_edge = -1;
  int          last_strobe_edge = -100;
  int          strobe_edges[$];
  logic [4:0]  strobe_addrs[$];
  logic        prev_strobe = 1'b0;
  logic        last_acc = 1'b0;
  logic [31:0] rf_model [32];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  function automatic void lookup(input logic [4:0] a, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = '0;
    if (a != 0) begin
      foreach (q[i]) begin
        if (q[i].a == a) begin
          h = 1'b1;
          d = q[i].d;
        end
      end
    end
  endfunction

  // One clock: drive inputs, check combinational outputs, advance model, check the write port.
  task automatic cycle(input logic v, input logic [4:0] r, input logic [31:0] d,
                       input logic [4:0] a1, input logic [4:0] a2, input logic rst);
    logic        acc, h;
    logic [31:0] fd;
    @(negedge clk);
    reset        = rst;
    bus.wb_valid = v;
    bus.wb_reg   = r;
    bus.wb_data  = d;
    register1    = a1;
    register2    = a2;
    #1;
    check("wb_ready", bus.wb_ready, (!rst && q.size() < DEPTH));
    if (!rst) begin
      check("count", count, q.size());
      lookup(a1, h, fd);
      check("hit1", hit1, h);
      check("fwd_data1", fwd_data1, fd);
      lookup(a2, h, fd);
      check("hit2", hit2, h);
      check("fwd_data2", fwd_data2, fd);
    end
    acc = v && !rst && (q.size() < DEPTH);
    last_acc = acc;
    @(posedge clk);
    edge_n++;
    if (rst) begin
      pushed -= q.size() - ((pop_timer > 0) ? 1 : 0);
      q.delete();
      pop_timer = 0;
    end else begin
      if (pop_timer > 0) begin
        pop_timer--;
        if (pop_timer == 0 && q.size() > 0) void'(q.pop_front());
      end
      if (acc) begin
        last_acc_edge = edge_n;
        if (r != 0) begin
          q.push_back(ent_t'{a: r, d: d});
          pushed++;
        end
      end
    end
    #1;
    if (rst) begin
      check("rst_regWrite", bus.rf_regWrite, 0);
      check("rst_writeregister", bus.rf_writeregister, 0);
      check("rst_data", bus.rf_data, 0);
    end else if (bus.rf_regWrite) begin
      check("strobe_width", prev_strobe, 0);
      check("strobe_pending", q.size() > 0, 1);
      if (q.size() > 0) begin
        check("strobe_addr", bus.rf_writeregister, q[0].a);
        check("strobe_data", bus.rf_data, q[0].d);
        rf_model[q[0].a] = q[0].d;
      end
      check("strobe_gap", (edge_n - last_strobe_edge) >= 3, 1);
      last_strobe_edge = edge_n;
      strobe_edges.push_back(edge_n);
      strobe_addrs.push_back(bus.rf_writeregister);
      strobes++;
      pop_timer = 2;
    end
    prev_strobe = rst ? 1'b0 : bus.rf_regWrite;
  endtask

  task automatic idle(input int n, input logic [4:0] a1);
    for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, a1, 5'd0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_edge;
    int s_before;
    foreach (rf_model[i]) rf_model[i] = '0;
    bus.wb_valid = 1'b0;
    bus.wb_reg   = '0;
    bus.wb_data  = '0;

    // Reset, then a single write: strobe two edges after acceptance.
    cycle(1'b0, 0, 0, 0, 0, 1'b1);
    cycle(1'b1, 3, 32'h33, 0, 0, 1'b1);
    strobe_edges.delete();
    cycle(1'b1, 5, 32'hAA, 5, 0, 1'b0);
    acc_edge = last_acc_edge;
    idle(6, 5);
    check("t1_strobes", strobe_edges.size(), 1);
    if (strobe_edges.size() > 0) check("t1_latency", strobe_edges[0] - acc_edge, 2);

    // Back-to-back fill, then a fifth write waits for space.
    strobe_edges.delete();
    strobe_addrs.delete();
    for (int i = 1; i <= 4; i++) cycle(1'b1, 5'(i), 32'(i * 'h11), 5'(i), 5'd2, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 5, 32'h55, 1, 5, 1'b0);
      if (last_acc) break;
    end
    check("t2_fifth_accepted", last_acc, 1);
    idle(20, 0);
    check("t2_strobes", strobe_edges.size(), 5);
    for (int i = 0; i < strobe_addrs.size() && i < 5; i++)
      check("t2_order", strobe_addrs[i], i + 1);
    for (int i = 1; i < strobe_edges.size(); i++)
      check("t2_spacing", strobe_edges[i] - strobe_edges[i-1], 3);

    // r0 write: handshake only.
    strobe_edges.delete();
    cycle(1'b1, 0, 32'hDEAD, 0, 0, 1'b0);
    check("t3_accepted", last_acc, 1);
    idle(6, 0);
    check("t3_no_strobe", strobe_edges.size(), 0);

    // Two writes to r7, forwarding youngest.
    strobe_edges.delete();
    cycle(1'b1, 7, 32'h1, 7, 7, 1'b0);
    cycle(1'b1, 7, 32'h2, 7, 0, 1'b0);
    idle(12, 7);
    check("t4_strobes", strobe_edges.size(), 2);
    check("t4_r7_final", rf_model[7], 32'h2);

    // Reset in the STROBE cycle with three entries queued.
    cycle(1'b1, 9, 32'h99, 0, 0, 1'b0);
    cycle(1'b1, 10, 32'hA0, 0, 0, 1'b0);
    cycle(1'b1, 11, 32'hB0, 0, 0, 1'b0);
    for (int i = 0; i < 10 && !prev_strobe; i++) idle(1, 9);
    check("t5_in_strobe", prev_strobe, 1);
    cycle(1'b0, 0, 0, 9, 10, 1'b1);
    s_before = strobes;
    idle(8, 10);
    check("t5_no_strobe_after_reset", strobes - s_before, 0);
    strobe_addrs.delete();
    cycle(1'b1, 12, 32'hC0, 12, 0, 1'b0);
    idle(6, 12);
    check("t5_post_strobes", strobe_addrs.size(), 1);
    if (strobe_addrs.size() > 0) check("t5_post_addr", strobe_addrs[0], 12);

    // Random traffic with frequent address collisions.
    for (int i = 0; i < 300; i++)
      cycle($urandom_range(0, 3) != 0, 5'($urandom_range(0, 9)), $urandom,
            5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)), 1'b0);
    // Saturated stretch: queue stays full across many pointer wraps.
    for (int i = 0; i < 90; i++)
      cycle(1'b1, 5'($urandom_range(1, 31)), $urandom,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b0);
    idle(30, 0);
    check("final_empty", q.size(), 0);
    check("final_commits", strobes, pushed);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
